wb_port_sequencer: RTL and testbench
====================================

// Module: wb_port_sequencer
// PURPOSE
//  Sequences the single 32-bit register-file write port. Two requesters share it:
//  - the pipeline write-back stage (Bus_D, including 64-bit MUL products)
//  - an auxiliary long-latency return path (valid/ready).
//  A 64-bit product is split into two consecutive 32-bit writes, to DA and DA+1.
//  Sits between the write-back mux and the register file in the top module.
// PARAMETERS
//  ADDR_W        5   register address width (32 registers)
//  DATA_W        32  register width; pl_data is 2*DATA_W
//  STARVE_LIMIT  4   cycles aux may wait before it preempts the pipeline; 0 = aux strict priority
// PORTS
//  clk       in   1         rising-edge clock
//  reset     in   1         asynchronous, active-high
//  pl_valid  in   1         pipeline write request (RW of write-back stage)
//  pl_wide   in   1         request is a 64-bit MUL product
//  pl_da     in   ADDR_W    destination register
//  pl_data   in   2*DATA_W  Bus_D; only [DATA_W-1:0] is used when pl_wide=0
//  pl_stall  out  1         port unavailable; pipeline holds pl_* stable
//  ax_valid  in   1         aux write request
//  ax_ready  out  1         aux request accepted this cycle when ax_valid=1
//  ax_da     in   ADDR_W    aux destination register
//  ax_data   in   DATA_W    aux write data
//  rf_we     out  1         register-file write enable (registered)
//  rf_wa     out  ADDR_W    register-file write address (registered)
//  rf_wd     out  DATA_W    register-file write data (registered)
//  busy      out  1         FSM in HI state
// BEHAVIOUR
//  Handshake and latency
//  - Pipeline accepted: pl_valid & ~pl_stall. Aux accepted: ax_valid & ax_ready.
//  - At most one acceptance per cycle.
//  - rf_* are registered: an accept at edge N produces rf_we/wa/wd during cycle N+1.
//  - Narrow write latency = 1. Wide writes: low half in N+1, high half in N+2.
//  FSM, two states
//  - IDLE, priority order:
//    (a) starve_cnt==STARVE_LIMIT & ax_valid -> grant aux; ax_ready=1, pl_stall=1.
//    (b) else pl_valid -> grant pipeline; ax_ready=0, pl_stall=0.
//        Write pl_data[31:0] to pl_da.
//        If pl_wide: latch pl_data[63:32] and (pl_da+1) mod 2^ADDR_W, then go to HI.
//    (c) else ax_valid -> grant aux; ax_ready=1.
//    (d) else no write; rf_we=0 next cycle.
//  - HI: write latched upper half to latched address. pl_stall=1, ax_ready=0, busy=1.
//    Always returns to IDLE after one cycle.
//  - pl_stall and ax_ready are combinational from state, starve_cnt and the valids.
//    They never depend on rf_* outputs.
//  Starvation counter (starve_cnt, saturating, width clog2(STARVE_LIMIT+1))
//  - Increments each cycle ax_valid & ~ax_ready.
//  - Saturates at STARVE_LIMIT.
//  - Clears on aux accept or when ax_valid=0.
//  Register 0
//  - Any write addressed to 0 is still accepted, but rf_we=0 in its write cycle.
//  - Applies to the wide upper half when pl_da=31 (wraps to 0): low half goes to
//    R31, high half is dropped.
//  Reset, asynchronous; all of the following apply immediately on reset:
//  - state=IDLE; rf_we=0, rf_wa=0, rf_wd=0; starve_cnt=0; latched hi data/addr=0; busy=0.
//  - Reset in HI discards the pending upper half; no write occurs after release.
//  Simultaneous events
//  - pl and aux both valid with starve_cnt<LIMIT: pipeline wins and starve_cnt increments.
//  - Aux arriving during HI counts as waiting.
// TESTING
//  - Narrow: pl_valid=1, pl_da=5, pl_data=0x...0000_1234 ->
//    next cycle rf_we=1, rf_wa=5, rf_wd=0x1234; pl_stall=0 throughout.
//  - Wide: pl_wide=1, pl_da=8, pl_data=0xAAAA_BBBB_CCCC_DDDD ->
//    cycle+1 writes R8=0xCCCCDDDD; cycle+2 writes R9=0xAAAABBBB; pl_stall=1 and busy=1
//    during HI.
//  - Wrap/R0: wide to pl_da=31 -> R31 gets low half; next cycle rf_we=0.
//    Narrow to pl_da=0 -> pl accepted, rf_we=0.
//  - Starvation, STARVE_LIMIT=4: pl_valid and ax_valid held high, ax_da=3, ax_data=0x77 ->
//    4 pipeline writes, then ax_ready=1 and pl_stall=1 for 1 cycle, R3=0x77 next cycle,
//    then pipeline resumes.
//  - Aux blocked by HI: wide pl accepted while ax_valid=1 -> ax_ready=0 in HI;
//    aux granted the following IDLE cycle if pl_valid=0.
//  - Reset in HI: assert reset during HI -> rf_we=0 immediately;
//    after release, no upper-half write and state=IDLE.

Source files
------------

// File: rtl/wb_port_sequencer.sv
// wb_port_sequencer: arbitrates the single register-file write port
// between the write-back stage and the aux return path.
module wb_port_sequencer #(
    parameter int ADDR_W       = 5,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                pl_valid,
    input  logic                pl_wide,
    input  logic [ADDR_W-1:0]   pl_da,
    input  logic [2*DATA_W-1:0] pl_data,
    output logic                pl_stall,
    input  logic                ax_valid,
    output logic                ax_ready,
    input  logic [ADDR_W-1:0]   ax_da,
    input  logic [DATA_W-1:0]   ax_data,
    output logic                rf_we,
    output logic [ADDR_W-1:0]   rf_wa,
    output logic [DATA_W-1:0]   rf_wd,
    output logic                busy
);

    // A limit of 0 still needs a 1-bit counter that simply stays at 0.
    localparam int CNT_W =
        (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    typedef enum logic {
        IDLE = 1'b0,
        HI   = 1'b1
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  starve_cnt;
    logic [ADDR_W-1:0] hi_addr;
    logic [DATA_W-1:0] hi_data;
    logic [ADDR_W-1:0] pl_da_inc;

    logic idle;
    logic starved;
    logic grant_pl;
    logic grant_ax;

    assign busy      = (state == HI);
    assign pl_da_inc = pl_da + ADDR_W'(1);

    // Handshake decode: HI blocks both; a saturated wait hands aux the port.
    always_comb begin
        idle     = (state == IDLE);
        starved  = (starve_cnt == CNT_MAX);
        ax_ready = idle & (starved | ~pl_valid);
        pl_stall = ~idle | (starved & ax_valid);
        grant_ax = ax_valid & ax_ready;
        grant_pl = pl_valid & ~pl_stall;
    end

    // Port FSM with registered write outputs; R0 writes are accepted but dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            rf_we   <= 1'b0;
            rf_wa   <= '0;
            rf_wd   <= '0;
            hi_addr <= '0;
            hi_data <= '0;
        end else begin
            unique case (state)
                HI: begin
                    rf_we <= |hi_addr;
                    rf_wa <= hi_addr;
                    rf_wd <= hi_data;
                    state <= IDLE;
                end
                IDLE: begin
                    unique case (1'b1)
                        grant_pl: begin
                            rf_we <= |pl_da;
                            rf_wa <= pl_da;
                            rf_wd <= pl_data[DATA_W-1:0];
                            if (pl_wide) begin
                                hi_addr <= pl_da_inc;
                                hi_data <= pl_data[2*DATA_W-1:DATA_W];
                                state   <= HI;
                            end
                        end
                        grant_ax: begin
                            rf_we <= |ax_da;
                            rf_wa <= ax_da;
                            rf_wd <= ax_data;
                        end
                        default: begin
                            rf_we <= 1'b0;
                        end
                    endcase
                end
                default: begin
                    state <= IDLE;
                    rf_we <= 1'b0;
                end
            endcase
        end
    end

    // Count cycles aux is left waiting; saturate, clear on accept or withdraw.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (!ax_valid || ax_ready) begin
            starve_cnt <= '0;
        end else if (starve_cnt != CNT_MAX) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_wb_port_sequencer.sv
// tb_wb_port_sequencer: directed scenarios plus random traffic
// checked against a queue-based model of the write port.
module tb_wb_port_sequencer;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        pl_valid, pl_wide;
    logic [4:0]  pl_da;
    logic [63:0] pl_data;
    logic        pl_stall;
    logic        ax_valid, ax_ready;
    logic [4:0]  ax_da;
    logic [31:0] ax_data;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
    logic        busy;

    always #5 clk = ~clk;

    wb_port_sequencer #(
        .ADDR_W(5), .DATA_W(32), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk), .reset(reset),
        .pl_valid(pl_valid), .pl_wide(pl_wide),
        .pl_da(pl_da), .pl_data(pl_data), .pl_stall(pl_stall),
        .ax_valid(ax_valid), .ax_ready(ax_ready),
        .ax_da(ax_da), .ax_data(ax_data),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd), .busy(busy)
    );

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    // Model: pending upper halves waiting for the port, and aux wait time.
    wr_t hi_q[$];
    int  wait_cnt;

    logic        e_stall, e_ready, e_busy, e_we;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
    logic        o_stall, o_ready, o_busy, o_we;
    logic [4:0]  o_wa;
    logic [31:0] o_wd;
    logic        cur_av;

    task automatic model_reset();
        hi_q.delete();
        wait_cnt = 0;
    endtask

    task automatic drive_idle();
        pl_valid = 0; pl_wide = 0; pl_da = 0; pl_data = 0;
        ax_valid = 0; ax_da = 0; ax_data = 0;
    endtask

    // One clock: drive, predict, sample handshake, then sample rf after the edge.
    task automatic cycle(input logic pv, input logic pw,
                         input logic [4:0] pda, input logic [63:0] pd,
                         input logic av, input logic [4:0] ada,
                         input logic [31:0] ad);
        logic in_hi, starved, g_pl, g_ax;
        wr_t  w;
        @(negedge clk);
        pl_valid = pv; pl_wide = pw; pl_da = pda; pl_data = pd;
        ax_valid = av; ax_da = ada; ax_data = ad;
        cur_av = av;
        #1;
        in_hi   = (hi_q.size() != 0);
        starved = (wait_cnt == LIMIT);
        g_ax    = !in_hi && av && (starved || !pv);
        g_pl    = !in_hi && pv && !(starved && av);
        e_stall = in_hi || (starved && av);
        e_ready = !in_hi && (starved || !pv);
        e_busy  = in_hi;
        o_stall = pl_stall;
        o_ready = ax_ready;
        o_busy  = busy;
        w = '0;
        e_we = 0;
        if (in_hi) begin
            w = hi_q.pop_front();
            e_we = 1;
        end else if (g_pl) begin
            w.a = pda; w.d = pd[31:0]; e_we = 1;
            if (pw) hi_q.push_back({5'(pda + 5'd1), pd[63:32]});
        end else if (g_ax) begin
            w.a = ada; w.d = ad; e_we = 1;
        end
        e_we = e_we && (w.a != 0);
        e_wa = w.a;
        e_wd = w.d;
        if (!av || g_ax) wait_cnt = 0;
        else if (wait_cnt < LIMIT) wait_cnt++;
        @(posedge clk);
        #1;
        o_we = rf_we; o_wa = rf_wa; o_wd = rf_wd;
    endtask

    task automatic test_reset();
        drive_idle();
        reset = 1;
        model_reset();
        #1;
        vectors++;
        if (rf_we !== 1'b0 || rf_wa !== 5'd0 || rf_wd !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_rf: got we=%b wa=%0d wd=%h want 0/0/0",
                     rf_we, rf_wa, rf_wd);
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_busy: got %b want 0", busy);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 0;
        cycle(0, 0, 0, 0, 0, 0, 0);
        vectors++;
        if (o_we !== 1'b0 || o_stall !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle: got we=%b stall=%b want 0/0", o_we, o_stall);
        end
    endtask

    task automatic test_narrow();
        cycle(1, 0, 5'd5, 64'hFFFF_0000_0000_1234, 0, 0, 0);
        vectors++;
        if (o_stall !== 1'b0) begin
            miscompares++;
            $display("FAIL narrow_stall: got %b want 0", o_stall);
        end
        vectors++;
        if (o_we !== 1'b1 || o_wa !== 5'd5 || o_wd !== 32'h1234) begin
            miscompares++;
            $display("FAIL narrow_write: got we=%b wa=%0d wd=%h want 1/5/1234",
                     o_we, o_wa, o_wd);
        end
        cycle(0, 0, 0, 0, 0, 0, 0);
        vectors++;
        if (o_we !== 1'b0) begin
            miscompares++;
            $display("FAIL narrow_after: got we=%b want 0", o_we);
        end
    endtask

    task automatic test_wide();
        cycle(1, 1, 5'd8, 64'hAAAA_BBBB_CCCC_DDDD, 0, 0, 0);
        vectors++;
        if (o_we !== 1'b1 || o_wa !== 5'd8 || o_wd !== 32'hCCCC_DDDD) begin
            miscompares++;
            $display("FAIL wide_lo: got we=%b wa=%0d wd=%h want 1/8/ccccdddd",
                     o_we, o_wa, o_wd);
        end
        cycle(0, 0, 0, 0, 0, 0, 0);
        vectors++;
        if (o_stall !== 1'b1 || o_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL wide_hi_flags: got stall=%b busy=%b want 1/1",
                     o_stall, o_busy);
        end
        vectors++;
        if (o_we !== 1'b1 || o_wa !== 5'd9 || o_wd !== 32'hAAAA_BBBB) begin
            miscompares++;
            $display("FAIL wide_hi: got we=%b wa=%0d wd=%h want 1/9/aaaabbbb",
                     o_we, o_wa, o_wd);
        end
        cycle(0, 0, 0, 0, 0, 0, 0);
        vectors++;
        if (o_busy !== 1'b0 || o_we !== 1'b0) begin
            miscompares++;
            $display("FAIL wide_done: got busy=%b we=%b want 0/0", o_busy, o_we);
        end
    endtask

    task automatic test_wrap_r0();
        cycle(1, 1, 5'd31, 64'h1111_2222_3333_4444, 0, 0, 0);
        vectors++;
        if (o_we !== 1'b1 || o_wa !== 5'd31 || o_wd !== 32'h3333_4444) begin
            miscompares++;
            $display("FAIL wrap_lo: got we=%b wa=%0d wd=%h want 1/31/33334444",
                     o_we, o_wa, o_wd);
        end
        cycle(0, 0, 0, 0, 0, 0, 0);
        vectors++;
        if (o_we !== 1'b0 || o_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL wrap_hi_dropped: got we=%b busy=%b want 0/1", o_we, o_busy);
        end
        cycle(1, 0, 5'd0, 64'h55, 0, 0, 0);
        vectors++;
        if (o_stall !== 1'b0 || o_we !== 1'b0) begin
            miscompares++;
            $display("FAIL r0_narrow: got stall=%b we=%b want 0/0", o_stall, o_we);
        end
    endtask

    task automatic test_starvation();
        logic [4:0] xa;
        cycle(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            cycle(1, 0, 5'(10 + i), 64'(i + 1), 1, 5'd3, 32'h77);
            xa = (i == 4) ? 5'd3 : 5'(10 + i);
            vectors++;
            if (o_stall !== (i == 4) || o_ready !== (i == 4)) begin
                miscompares++;
                $display("FAIL starve_hs[%0d]: got stall=%b ready=%b want %b/%b",
                         i, o_stall, o_ready, i == 4, i == 4);
            end
            vectors++;
            if (o_we !== 1'b1 || o_wa !== xa) begin
                miscompares++;
                $display("FAIL starve_wa[%0d]: got we=%b wa=%0d want 1/%0d",
                         i, o_we, o_wa, xa);
            end
            if (i == 4) begin
                vectors++;
                if (o_wd !== 32'h77) begin
                    miscompares++;
                    $display("FAIL starve_wd: got %h want 77", o_wd);
                end
            end
        end
        cycle(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_aux_blocked_by_hi();
        cycle(1, 1, 5'd12, 64'h0000_DEAD_0000_BEEF, 1, 5'd7, 32'h99);
        vectors++;
        if (o_ready !== 1'b0 || o_wa !== 5'd12 || o_wd !== 32'hBEEF) begin
            miscompares++;
            $display("FAIL blk_pl: got ready=%b wa=%0d wd=%h want 0/12/beef",
                     o_ready, o_wa, o_wd);
        end
        cycle(0, 0, 0, 0, 1, 5'd7, 32'h99);
        vectors++;
        if (o_ready !== 1'b0 || o_stall !== 1'b1 || o_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL blk_hi: got ready=%b stall=%b busy=%b want 0/1/1",
                     o_ready, o_stall, o_busy);
        end
        vectors++;
        if (o_wa !== 5'd13 || o_wd !== 32'hDEAD) begin
            miscompares++;
            $display("FAIL blk_hi_wr: got wa=%0d wd=%h want 13/dead", o_wa, o_wd);
        end
        cycle(0, 0, 0, 0, 1, 5'd7, 32'h99);
        vectors++;
        if (o_ready !== 1'b1 || o_we !== 1'b1 || o_wa !== 5'd7 || o_wd !== 32'h99) begin
            miscompares++;
            $display("FAIL blk_aux: got ready=%b we=%b wa=%0d wd=%h want 1/1/7/99",
                     o_ready, o_we, o_wa, o_wd);
        end
        cycle(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset_in_hi();
        cycle(1, 1, 5'd20, 64'h0123_4567_89AB_CDEF, 0, 0, 0);
        @(negedge clk);
        drive_idle();
        reset = 1;
        model_reset();
        #1;
        vectors++;
        if (rf_we !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_hi_now: got we=%b busy=%b want 0/0", rf_we, busy);
        end
        @(posedge clk);
        @(negedge clk);
        reset = 0;
        cycle(0, 0, 0, 0, 0, 0, 0);
        vectors++;
        if (o_we !== 1'b0 || o_busy !== 1'b0 || o_stall !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_hi_after: got we=%b busy=%b stall=%b want 0/0/0",
                     o_we, o_busy, o_stall);
        end
        cycle(1, 0, 5'd2, 64'h42, 0, 0, 0);
        vectors++;
        if (o_we !== 1'b1 || o_wa !== 5'd2 || o_wd !== 32'h42) begin
            miscompares++;
            $display("FAIL rst_hi_resume: got we=%b wa=%0d wd=%h want 1/2/42",
                     o_we, o_wa, o_wd);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            cycle(($urandom % 10) < 7, ($urandom % 3) == 0,
                  5'($urandom), {$urandom, $urandom},
                  ($urandom % 2) == 0, 5'($urandom), $urandom);
            vectors++;
            if (o_stall !== e_stall || o_busy !== e_busy) begin
                miscompares++;
                $display("FAIL rnd_flags[%0d]: got stall=%b busy=%b want %b/%b",
                         n, o_stall, o_busy, e_stall, e_busy);
            end
            if (cur_av) begin
                vectors++;
                if (o_ready !== e_ready) begin
                    miscompares++;
                    $display("FAIL rnd_ready[%0d]: got %b want %b", n, o_ready, e_ready);
                end
            end
            vectors++;
            if (o_we !== e_we || (e_we && (o_wa !== e_wa || o_wd !== e_wd))) begin
                miscompares++;
                $display("FAIL rnd_write[%0d]: got %b/%0d/%h want %b/%0d/%h",
                         n, o_we, o_wa, o_wd, e_we, e_wa, e_wd);
            end
        end
    endtask

    initial begin
        test_reset();
        test_narrow();
        test_wide();
        test_wrap_r0();
        test_starvation();
        test_aux_blocked_by_hi();
        test_reset_in_hi();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
